// File: rtl/uart_rx_pkg.sv
// Shared clock constant, state encoding and baud helper for the UART receiver.
package uart_rx_pkg;

    localparam int UART_CLK_FREQ = 48_000_000;

    // Encoding is shared with the transmitter so both ends read the same in debug dumps.
    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        START_BIT      = 3'd1,
        DATA           = 3'd2,
        PARITY         = 3'd3,
        STOP_BIT_FIRST = 3'd4,
        STOP_BIT_LAST  = 3'd5
    } rx_state_e;

    function automatic int baud_cnt(input int baud_rate);
        return UART_CLK_FREQ / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer with a selectable reset value, for bringing async lines into clk.
module uart_rx_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 or 2 stop bits, valid/ready output
// with parity, framing and overrun status.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       cfg_en_i,
    input  logic       cfg_stop_bits_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       err_parity_o,
    output logic       err_frame_o,
    output logic       err_overrun_o
);

    localparam int               BAUD_CNT = baud_cnt(BAUD_RATE);
    localparam int               CNT_W    = $clog2(BAUD_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BAUD_CNT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT / 2);

    rx_state_e        state;
    logic [CNT_W-1:0] bit_timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             parity_acc;
    logic             parity_err_pend;
    logic             frame_err_pend;
    logic             rx_sync;
    logic             rx_prev;
    logic             falling_edge;
    logic             at_mid;
    logic             at_end;
    logic             frame_err_final;
    logic             deliver;

    uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_i),
        .q   (rx_sync)
    );

    assign falling_edge    = rx_prev & ~rx_sync;
    assign at_mid          = (bit_timer == CNT_MID);
    assign at_end          = (bit_timer == CNT_END);
    assign frame_err_final = frame_err_pend | ~rx_sync;
    // The frame completes on the sample of the last stop bit, whichever one that is.
    assign deliver = cfg_en_i && at_end &&
                     (((state == STOP_BIT_FIRST) && !cfg_stop_bits_i) || (state == STOP_BIT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bit_timer       <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            parity_acc      <= 1'b0;
            parity_err_pend <= 1'b0;
            frame_err_pend  <= 1'b0;
            rx_prev         <= 1'b1;
            rx_data_o       <= '0;
            rx_valid_o      <= 1'b0;
            err_parity_o    <= 1'b0;
            err_frame_o     <= 1'b0;
            err_overrun_o   <= 1'b0;
        end else begin
            rx_prev       <= rx_sync;
            err_overrun_o <= 1'b0;

            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            if (deliver) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o    <= shift_reg;
                    err_parity_o <= parity_err_pend;
                    err_frame_o  <= frame_err_final;
                    rx_valid_o   <= 1'b1;
                end else begin
                    err_overrun_o <= 1'b1;
                end
            end

            if (!cfg_en_i) begin
                state     <= IDLE;
                bit_timer <= '0;
            end else begin
                bit_timer <= (state == IDLE || at_end) ? '0 : bit_timer + 1'b1;
                case (state)
                    IDLE: begin
                        if (falling_edge) begin
                            state           <= START_BIT;
                            bit_idx         <= '0;
                            parity_acc      <= 1'b0;
                            parity_err_pend <= 1'b0;
                            frame_err_pend  <= 1'b0;
                        end
                    end
                    START_BIT: begin
                        // Restarting the timer here puts every later sample at mid-bit.
                        if (at_mid) begin
                            bit_timer <= '0;
                            state     <= rx_sync ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (at_end) begin
                            shift_reg  <= {rx_sync, shift_reg[7:1]};
                            parity_acc <= parity_acc ^ rx_sync;
                            bit_idx    <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (at_end) begin
                            parity_err_pend <= (rx_sync != parity_acc);
                            state           <= STOP_BIT_FIRST;
                        end
                    end
                    STOP_BIT_FIRST: begin
                        if (at_end) begin
                            frame_err_pend <= frame_err_final;
                            state          <= cfg_stop_bits_i ? STOP_BIT_LAST : IDLE;
                        end
                    end
                    STOP_BIT_LAST: begin
                        if (at_end) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-period line model, random frames checked against
// a frame-level reference model, plus directed break/glitch/overrun/enable/reset scenarios.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BAUD_CNT  = 15;
    localparam int P         = BAUD_CNT + 1;
    localparam int BAUD_RATE = UART_CLK_FREQ / BAUD_CNT;
    // Stop bit is sampled 2 sync clocks + 1 edge-detect clock + half a bit after it begins.
    localparam int STOP_SAMPLE_TICK = 2 + 1 + BAUD_CNT / 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       cfg_en_i = 1'b1;
    logic       cfg_stop_bits_i = 1'b0;
    logic       rx_ready_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       err_parity_o;
    logic       err_frame_o;
    logic       err_overrun_o;

    int   checks = 0;
    int   failures = 0;
    int   overrun_cnt = 0;
    int   valid_cycles = 0;
    rec_t got_q[$];

    uart_rx #(.BAUD_RATE(BAUD_RATE)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_i            (rx_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_stop_bits_i (cfg_stop_bits_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .err_parity_o    (err_parity_o),
        .err_frame_o     (err_frame_o),
        .err_overrun_o   (err_overrun_o)
    );

    always #5 clk = ~clk;

    // Records every completed handshake and counts overrun pulses and valid cycles.
    always @(negedge clk) begin
        if (rx_valid_o && rx_ready_i) got_q.push_back({rx_data_o, err_parity_o, err_frame_o});
        if (err_overrun_o) overrun_cnt++;
        if (rx_valid_o) valid_cycles++;
    end

    function automatic rec_t model_frame(input logic [7:0] d, input logic par, input logic s1,
                                         input logic s2, input int nstop);
        rec_t r;
        r.data = d;
        r.perr = (par != ^d);
        r.ferr = (s1 == 1'b0) || (nstop == 2 && s2 == 1'b0);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input logic b, input int pulse_at);
        rx_i = b;
        for (int c = 0; c < P; c++) begin
            if (pulse_at >= 0 && c == pulse_at) rx_ready_i = 1'b1;
            else if (pulse_at >= 0 && c == pulse_at + 1) rx_ready_i = 1'b0;
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input logic s2,
                              input int nstop, input int pulse_at);
        drive_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], -1);
        drive_bit(par, -1);
        if (nstop == 2) begin
            drive_bit(s1, -1);
            drive_bit(s2, pulse_at);
        end else begin
            drive_bit(s1, pulse_at);
        end
        rx_i = 1'b1;
    endtask

    task automatic wait_got(output bit ok);
        int n = 0;
        while (got_q.size() == 0 && n < 4 * P) begin
            tick(1);
            n++;
        end
        ok = (got_q.size() != 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_i = 1'b1;
        tick(3);
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid_o); end
        checks++; if (rx_data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %02h expected 00", rx_data_o); end
        checks++; if (err_parity_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr: got %b expected 0", err_parity_o); end
        checks++; if (err_frame_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr: got %b expected 0", err_frame_o); end
        checks++; if (err_overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovr: got %b expected 0", err_overrun_o); end
        rst = 1'b0;
        tick(2 * P);
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid: got %b expected 0", rx_valid_o); end
    endtask

    task automatic test_basic(input logic [7:0] d, input logic par, input string name);
        rec_t exp, got;
        bit   ok;
        got_q.delete();
        valid_cycles = 0;
        exp = model_frame(d, par, 1'b1, 1'b1, 1);
        send_frame(d, par, 1'b1, 1'b1, 1, -1);
        wait_got(ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL %s_timeout: got no byte expected %02h", name, d);
        end else begin
            got = got_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL %s_frame: got %02h p%b f%b expected %02h p%b f%b",
                         name, got.data, got.perr, got.ferr, exp.data, exp.perr, exp.ferr);
            end
        end
        tick(P);
        checks++; if (valid_cycles !== 1) begin failures++; $display("[TB] FAIL %s_valid_len: got %0d expected 1", name, valid_cycles); end
    endtask

    task automatic test_random(input int n);
        rec_t       exp, got;
        bit         ok;
        logic [7:0] d;
        logic       par, s1, s2;
        int         kind, nstop;
        int         ovr0 = overrun_cnt;
        got_q.delete();
        for (int k = 0; k < n; k++) begin
            d     = 8'($urandom);
            kind  = $urandom_range(0, 5);
            nstop = $urandom_range(1, 2);
            par   = (^d) ^ (kind == 0);
            s1    = (kind != 1);
            s2    = (kind != 2);
            cfg_stop_bits_i = (nstop == 2);
            exp = model_frame(d, par, s1, s2, nstop);
            send_frame(d, par, s1, s2, nstop, -1);
            if ((nstop == 1 && !s1) || (nstop == 2 && !s2)) tick(P);
            wait_got(ok);
            checks++;
            if (!ok) begin
                failures++; $display("[TB] FAIL rand%0d_timeout: got no byte expected %02h", k, d);
            end else begin
                got = got_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_frame: got %02h p%b f%b expected %02h p%b f%b",
                             k, got.data, got.perr, got.ferr, exp.data, exp.perr, exp.ferr);
                end
            end
        end
        cfg_stop_bits_i = 1'b0;
        tick(P);
        checks++; if (overrun_cnt !== ovr0) begin failures++; $display("[TB] FAIL rand_overrun: got %0d expected %0d", overrun_cnt - ovr0, 0); end
    endtask

    task automatic test_break;
        rec_t exp, got;
        bit   ok;
        got_q.delete();
        exp = model_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1, -1);
        tick(2 * P);
        wait_got(ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL stop0_timeout: got no byte expected 3c");
        end else begin
            got = got_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL stop0_frame: got %02h p%b f%b expected %02h p%b f%b",
                         got.data, got.perr, got.ferr, exp.data, exp.perr, exp.ferr);
            end
        end
        rx_i = 1'b0;
        tick(20 * P);
        checks++; if (got_q.size() !== 1) begin failures++; $display("[TB] FAIL break_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() != 0) begin
            got = got_q.pop_front();
            checks++;
            if (got !== rec_t'({8'h00, 1'b0, 1'b1})) begin
                failures++; $display("[TB] FAIL break_frame: got %02h p%b f%b expected 00 p0 f1", got.data, got.perr, got.ferr);
            end
        end
        rx_i = 1'b1;
        tick(2 * P);
        checks++; if (got_q.size() !== 0) begin failures++; $display("[TB] FAIL break_release: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_glitch;
        int v0;
        got_q.delete();
        v0 = valid_cycles;
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(2 * P);
        checks++; if (valid_cycles !== v0) begin failures++; $display("[TB] FAIL glitch_valid: got %0d expected %0d", valid_cycles - v0, 0); end
        test_basic(8'h96, 1'b0, "after_glitch");
    endtask

    task automatic test_overrun;
        rec_t got;
        int   ovr0;
        got_q.delete();
        rx_ready_i = 1'b0;
        ovr0 = overrun_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1, -1);
        tick(P);
        checks++; if (rx_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL ovr_valid: got %b expected 1", rx_valid_o); end
        checks++; if (rx_data_o !== 8'h11) begin failures++; $display("[TB] FAIL ovr_data: got %02h expected 11", rx_data_o); end
        checks++; if (overrun_cnt - ovr0 !== 1) begin failures++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", overrun_cnt - ovr0); end
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL ovr_accept: got %b expected 0", rx_valid_o); end
        checks++; if (got_q.size() !== 1) begin failures++; $display("[TB] FAIL ovr_count: got %0d expected 1", got_q.size()); end
        got_q.delete();
        ovr0 = overrun_cnt;
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1, -1);
        send_frame(8'h44, 1'b0, 1'b1, 1'b1, 1, STOP_SAMPLE_TICK);
        checks++; if (overrun_cnt - ovr0 !== 0) begin failures++; $display("[TB] FAIL same_cycle_ovr: got %0d expected 0", overrun_cnt - ovr0); end
        checks++; if (rx_data_o !== 8'h44 || rx_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL same_cycle_load: got %02h v%b expected 44 v1", rx_data_o, rx_valid_o); end
        checks++;
        if (got_q.size() == 0) begin
            failures++; $display("[TB] FAIL same_cycle_accept: got nothing expected 33");
        end else begin
            got = got_q.pop_front();
            if (got.data !== 8'h33) begin failures++; $display("[TB] FAIL same_cycle_accept: got %02h expected 33", got.data); end
        end
        rx_ready_i = 1'b1;
        tick(2);
        got_q.delete();
    endtask

    task automatic test_two_stop;
        rec_t exp, got;
        bit   ok;
        got_q.delete();
        cfg_stop_bits_i = 1'b1;
        exp = model_frame(8'hC3, 1'b0, 1'b1, 1'b0, 2);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 2, -1);
        tick(P);
        wait_got(ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL stop2_timeout: got no byte expected c3");
        end else begin
            got = got_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL stop2_frame: got %02h p%b f%b expected %02h p%b f%b",
                         got.data, got.perr, got.ferr, exp.data, exp.perr, exp.ferr);
            end
        end
        cfg_stop_bits_i = 1'b0;
    endtask

    task automatic test_enable_drop;
        logic [7:0] d = 8'hF0;
        got_q.delete();
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
        cfg_en_i = 1'b0;
        for (int i = 4; i < 8; i++) drive_bit(d[i], -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        tick(2 * P);
        checks++; if (got_q.size() !== 0 || rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL en_drop: got %0d bytes v%b expected 0 v0", got_q.size(), rx_valid_o); end
        cfg_en_i = 1'b1;
        tick(P);
        test_basic(8'h5A, 1'b0, "after_enable");
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d = 8'hFF;
        got_q.delete();
        drive_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12 * P);
        checks++; if (got_q.size() !== 0 || rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid: got %0d bytes v%b expected 0 v0", got_q.size(), rx_valid_o); end
        test_basic(8'h81, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5, 1'b0, "basic_a5");
        test_basic(8'h01, 1'b0, "parity_01");
        test_random(24);
        test_break();
        test_glitch();
        test_overrun();
        test_two_stop();
        test_enable_drop();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
